// File: rtl/dmem_if.sv
// Request/response handshake bundle between the core load/store path and dmem_hs.
interface dmem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_hs.sv
// Word-addressed data memory with valid/ready handshake, wait states, byte enables,
// misalign/range error reporting and an optional post-reset zero sweep.
module dmem_hs #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 64,
  parameter int ADDR_W         = 32,
  parameter int WAIT_CYCLES    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  dmem_if.slave  bus,
  output logic   busy
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;

  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off_mask;
    off_mask = ADDR_W'(BYTES - 1);
    return (|(a & off_mask)) || ((a >> OFF_W) >= ADDR_W'(DEPTH));
  endfunction

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  clr_idx;
  logic [3:0]        wait_cnt;

  logic              we_p0, err_p0;
  logic [IDX_W-1:0]  idx_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [BYTES-1:0]  be_p0;

  logic [DATA_W-1:0] rdata_p1;
  logic              err_p1;

  logic              cur_we, cur_err;
  logic [IDX_W-1:0]  cur_idx;
  logic [DATA_W-1:0] cur_wdata;
  logic [BYTES-1:0]  cur_be;

  logic              accept, enter_resp, rsp_fire, req_ready, rsp_valid;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [BYTES-1:0]  wr_be;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (CLEAR_ON_RESET != 0) state <= CLEAR;
      else                     state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    enter_resp = 1'b0;
    rsp_fire   = 1'b0;
    case (state)
      CLEAR: begin
        busy = 1'b1;
        if (clr_idx == IDX_W'(DEPTH - 1)) state_nxt = IDLE;
      end
      IDLE: begin
        // Held low while reset is asserted so nothing is accepted during reset.
        req_ready = rst_n;
        if (bus.req_valid && rst_n) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_nxt = WAIT;
          end else begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          rsp_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge, so use the live request.
  always_comb begin
    if (state == IDLE) begin
      cur_we    = bus.req_we;
      cur_err   = addr_err(bus.req_addr);
      cur_idx   = bus.req_addr[OFF_W +: IDX_W];
      cur_wdata = bus.req_wdata;
      cur_be    = bus.req_be;
    end else begin
      cur_we    = we_p0;
      cur_err   = err_p0;
      cur_idx   = idx_p0;
      cur_wdata = wdata_p0;
      cur_be    = be_p0;
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = cur_idx;
    wr_data = cur_wdata;
    wr_be   = cur_be;
    if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_idx  = clr_idx;
      wr_data = '0;
      wr_be   = '1;
    end else if (enter_resp && cur_we && !cur_err) begin
      wr_en = 1'b1;
    end
  end

  // ---- stage p0: request capture on accept ----
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= bus.req_we;
      err_p0   <= addr_err(bus.req_addr);
      idx_p0   <= bus.req_addr[OFF_W +: IDX_W];
      wdata_p0 <= bus.req_wdata;
      be_p0    <= bus.req_be;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && rst_n) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // ---- stage p1: response registers, loaded on the edge entering RESP ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_idx  <= '0;
      wait_cnt <= '0;
      rdata_p1 <= '0;
      err_p1   <= 1'b0;
    end else begin
      if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
      if (accept)              wait_cnt <= '0;
      else if (state == WAIT)  wait_cnt <= wait_cnt + 1'b1;
      if (enter_resp) begin
        err_p1   <= cur_err;
        rdata_p1 <= (cur_err || cur_we) ? '0 : mem[cur_idx];
      end else if (rsp_fire) begin
        err_p1   <= 1'b0;
        rdata_p1 <= '0;
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rdata_p1;
  assign bus.rsp_err   = err_p1;

endmodule
